// File: rtl/multicycle_main_control_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALU op codes,
// controller state numbering and datapath mux selects.
package multicycle_main_control_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  // Bit 2 is reserved for future ALU-control extensions and is never driven.
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_main_control_mem_watchdog.sv
// Per-access timeout counter: counts stalled memory cycles and flags the cycle
// on which the access has waited TIMEOUT cycles without completing.
module multicycle_main_control_mem_watchdog #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] cnt;

  assign expire = (TIMEOUT != 0) && enable && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (enable)  cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Moore main control FSM for the multicycle MIPS datapath, with a watchdog that
// aborts memory accesses whose ready handshake never arrives.
module multicycle_main_control
  import multicycle_main_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] alu_op,
  output logic       illegal_op,
  output logic       mem_fault,
  output logic [3:0] state
);

  state_t cur, nxt;
  logic   expire;

  // A fault re-entering FETCH from FETCH still counts as a fresh access.
  multicycle_main_control_mem_watchdog #(
    .TIMEOUT (MEM_TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  ((nxt != cur) || expire),
    .enable (is_mem_state(cur) && !mem_ready),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) cur <= S_FETCH;
    else     cur <= nxt;
  end

  assign state = rst ? S_FETCH : cur;

  always_comb begin
    nxt           = cur;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    pc_source     = PCSRC_ALU;
    alu_op        = ALUOP_ADD;
    illegal_op    = 1'b0;
    mem_fault     = expire;

    case (cur)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready)   nxt = S_DECODE;
        else if (expire) nxt = S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW:   nxt = S_MEM_ADDR;
          OP_R:           nxt = S_EXEC_R;
          OP_BEQ, OP_BNE: nxt = S_BRANCH;
          OP_J:           nxt = S_JUMP;
          OP_ADDI:        nxt = S_ADDI_EXEC;
          default: begin
            illegal_op = 1'b1;
            nxt        = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        nxt       = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready)   nxt = S_MEM_WB;
        else if (expire) nxt = S_FETCH;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        nxt        = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready || expire) nxt = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        nxt       = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        nxt       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        branch_ne     = (opcode == OP_BNE);
        nxt           = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        nxt       = S_FETCH;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        nxt       = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        nxt       = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase

    // Reset silences every strobe in the same cycle, abandoning any access.
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_ne     = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      pc_source     = PCSRC_ALU;
      alu_op        = ALUOP_ADD;
      illegal_op    = 1'b0;
      mem_fault     = 1'b0;
    end
  end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multicycle MIPS datapath; the producer of the 3-bit alu_op bus consumed by the ALU control block, plus all datapath strobes.
- Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK per instruction from the 6-bit opcode, stalling on a memory-ready handshake.
- A per-access watchdog aborts hung memory accesses.

Parameters:
- MEM_TIMEOUT, 15, max cycles any memory state waits for mem_ready; 0 disables the watchdog.
- CNT_W, 4, width of the watchdog counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  instr[31:26] from the instruction register
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if branch condition holds
- branch_ne  out  1  1 = bne (take on !zero), 0 = beq (take on zero)
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  register write data: 1 = MDR, 0 = ALUOut
- reg_dst  out  1  destination register: 1 = rd, 0 = rt
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A operand: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU B operand: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- pc_source  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_op  out  3  ALU operation: 000 = add, 001 = subtract, 010 = use funct; bit 2 is reserved and always 0
- illegal_op  out  1  one-cycle pulse when an unknown opcode is decoded
- mem_fault  out  1  one-cycle pulse on watchdog expiry
- state  out  4  current state, for debug

Behaviour:
- Opcodes:
  - R = 000000, LW = 100011, SW = 101011, BEQ = 000100, BNE = 000101, J = 000010, ADDI = 001000.
- Moore outputs, decoded from the registered state.
  - mem_fault, and the fetch-completion strobes ir_write and pc_write, are additionally qualified by mem_ready or the counter.
- Reset:
  - While rst=1: state <= FETCH, counter <= 0.
  - While rst=1: all outputs forced 0, including alu_op = 000 and state reads FETCH.
  - Reset mid-instruction abandons the instruction with no writes.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00.
  - When mem_ready=1: ir_write=1, pc_write=1, go to DECODE.
  - Otherwise hold.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALUOut).
  - Next state: LW/SW -> MEM_ADDR; R -> EXEC_R; BEQ/BNE -> BRANCH; J -> JUMP; ADDI -> ADDI_EXEC.
  - Any other opcode: illegal_op=1 for this cycle, go to FETCH.
- MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=000.
  - Next state: LW -> MEM_RD, SW -> MEM_WR.
- MEM_RD:
  - Outputs: mem_read=1, i_or_d=1.
  - mem_ready -> MEM_WB.
- MEM_WB:
  - Outputs: reg_write=1, mem_to_reg=1, reg_dst=0.
  - Next state: FETCH.
- MEM_WR:
  - Outputs: mem_write=1, i_or_d=1.
  - mem_ready -> FETCH.
- EXEC_R:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=010.
  - Next state: R_WB.
- R_WB:
  - Outputs: reg_write=1, reg_dst=1, mem_to_reg=0.
  - Next state: FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01.
  - branch_ne = (opcode==BNE).
  - Next state: FETCH.
- JUMP:
  - Outputs: pc_write=1, pc_source=10.
  - Next state: FETCH.
- ADDI_EXEC:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=000.
  - Next state: ADDI_WB.
- ADDI_WB:
  - Outputs: reg_write=1, reg_dst=0, mem_to_reg=0.
  - Next state: FETCH.
- Defaults: outputs not listed for a state are 0.
- Watchdog (memory states FETCH, MEM_RD, MEM_WR):
  - Counter clears on entering any memory state and increments each cycle mem_ready=0.
  - If counter==MEM_TIMEOUT-1 with mem_ready=0 and MEM_TIMEOUT!=0: mem_fault=1 for that cycle, go to FETCH, no ir_write/pc_write/reg_write.
  - mem_ready=1 on the expiry cycle wins: normal completion, no fault.
- Latency with mem_ready tied high:
  - R and ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ/BNE and J: 3 cycles.
- mem_ready outside memory states is ignored.
- opcode is sampled only in DECODE and MEM_ADDR; BRANCH reads it for branch_ne.
- opcode is stable from the IR, which only loads in FETCH.

Decomposition:
- Shared package:
  - Opcode constants.
  - alu_op encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT).
  - 4-bit state encoding.
  - alu_src_b and pc_source select encodings.
- Package is shared with the ALU control block and the datapath.
- One sub-module: mem_watchdog (counter, clear, enable, expire).

Test Plan:
- rst held 3 cycles with mem_ready=1, then released -> all outputs 0 during reset; first cycle after shows FETCH with mem_read=1, ir_write=1, pc_write=1, alu_op=000.
- opcode=000000, mem_ready=1 -> states FETCH, DECODE, EXEC_R (alu_op=010), R_WB (reg_write=1, reg_dst=1), FETCH; 4 cycles.
- opcode=100011 with mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles; then MEM_WB with mem_to_reg=1, reg_write=1; SW (101011) variant asserts mem_write=1, i_or_d=1 and never reg_write.
- opcode=000101 -> BRANCH shows alu_op=001, pc_write_cond=1, branch_ne=1, pc_source=01; opcode=000100 gives branch_ne=0.
- opcode=111111 -> illegal_op pulses 1 cycle in DECODE, next state FETCH, no writes.
- mem_ready=0 in FETCH, MEM_TIMEOUT=15 -> mem_fault pulses on the 15th cycle, ir_write stays 0, FETCH re-entered; rst asserted mid-MEM_WR -> mem_write drops the same cycle, FETCH.
